// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Debounces one raw push-button and a 3-bit slide-switch bank.
//
// The button runs through a two-flop synchroniser and a four-state FSM
// (IDLE -> PRESS_WAIT -> HELD -> RELEASE_WAIT -> IDLE). A level change must
// stay stable for DEBOUNCE_CNT synchronised cycles before the FSM accepts it.
// A registered strobe marks each accepted press and release. A separate hold
// counter raises a single long-press strobe once the button has stayed in the
// debounced-held condition for LONG_CNT cycles.
//
// The switches share one stability counter. The debounced vector updates only
// after the synchronised vector has held one value for DEBOUNCE_CNT cycles.
//
// Parameters
//   DEBOUNCE_CNT  stable cycles that qualify a change (2 .. 2^CNT_WIDTH-1)
//   CNT_WIDTH     width of the debounce counters
//   LONG_CNT      held cycles before long_pulse (1 .. 2^LONG_WIDTH-1)
//   LONG_WIDTH    width of the hold counter
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   button         in   raw push-button, 1 = pressed
//   sw_in[2:0]     in   raw switches: [1:0] frequency select, [2] direction
//   btn_level      out  debounced button level
//   press_pulse    out  one-cycle strobe on a debounced press
//   release_pulse  out  one-cycle strobe on a debounced release
//   long_pulse     out  one-cycle strobe after LONG_CNT held cycles
//   sw_out[2:0]    out  debounced switches, same bit mapping as sw_in
//
// All outputs come straight from flops. No input reaches an output
// through combinational logic only.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CNT = 2000000,
  parameter int CNT_WIDTH    = 21,
  parameter int LONG_CNT     = 100000000,
  parameter int LONG_WIDTH   = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] sw_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [2:0] sw_out
);

  localparam logic [CNT_WIDTH-1:0]  DEB_MAX  = CNT_WIDTH'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [LONG_WIDTH-1:0] LONG_MAX = LONG_WIDTH'(LONG_CNT - 1);
  localparam logic [LONG_WIDTH-1:0] HOLD_ONE = LONG_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  // Synchroniser flops
  logic                  r_btn_s1;
  logic                  r_btn_s2;
  logic [2:0]            r_sw_s1;
  logic [2:0]            r_sw_s2;

  // Button FSM state and counters
  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [LONG_WIDTH-1:0] r_hold;
  logic                  r_long_done;

  // Registered button outputs
  logic                  r_btn_level;
  logic                  r_press;
  logic                  r_release;
  logic                  r_long;

  // Switch filter
  logic [2:0]            r_sw_prev;
  logic [CNT_WIDTH-1:0]  r_sw_cnt;
  logic [2:0]            r_sw_out;

  // Next-state values
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [LONG_WIDTH-1:0] w_hold_nxt;
  logic                  w_long_done_nxt;
  logic                  w_press_nxt;
  logic                  w_release_nxt;
  logic                  w_long_nxt;
  logic                  w_sw_stable;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Only the second stage feeds any other logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= 3'b000;
      r_sw_s2  <= 3'b000;
    end else begin
      r_btn_s1 <= button;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Button FSM: state, counters and output strobes are registered together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_long_done <= 1'b0;
      r_btn_level <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_long_done <= w_long_done_nxt;
      r_btn_level <= (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_WAIT);
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_long_done_nxt = r_long_done;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_btn_s2) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end

      S_PRESS_WAIT: begin
        if (!r_btn_s2) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == DEB_MAX) begin
          w_state_nxt     = S_HELD;
          w_hold_nxt      = '0;
          w_long_done_nxt = 1'b0;
          w_press_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      S_HELD: begin
        if (!r_btn_s2) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
        // The hold counter saturates. The done flag keeps the long
        // strobe to a single pulse per press, including when a release
        // glitch drops the FSM back into HELD with the counter still full.
        if (r_hold == LONG_MAX) begin
          if (!r_long_done) begin
            w_long_nxt      = 1'b1;
            w_long_done_nxt = 1'b1;
          end
        end else begin
          w_hold_nxt = r_hold + HOLD_ONE;
        end
      end

      S_RELEASE_WAIT: begin
        // The hold counter is left untouched, so a brief release glitch
        // does not restart the long-press timing.
        if (r_btn_s2) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == DEB_MAX) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Switch filter: one counter shared by all three bits. It restarts on any
  // change of the synchronised vector. The output updates only when the
  // vector has been stable for the full window. Requiring stability in the
  // current cycle as well stops a counter that saturated on the previous
  // value from passing a fresh change through at once.
  // ---------------------------------------------------------------------------
  assign w_sw_stable = (r_sw_s2 == r_sw_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_prev <= 3'b000;
      r_sw_cnt  <= '0;
      r_sw_out  <= 3'b000;
    end else begin
      r_sw_prev <= r_sw_s2;
      if (!w_sw_stable) begin
        r_sw_cnt <= '0;
      end else if (r_sw_cnt != DEB_MAX) begin
        r_sw_cnt <= r_sw_cnt + CNT_ONE;
      end
      if (w_sw_stable && (r_sw_cnt == DEB_MAX) && (r_sw_s2 != r_sw_out)) begin
        r_sw_out <= r_sw_s2;
      end
    end
  end

  assign btn_level     = r_btn_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign sw_out        = r_sw_out;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CNT=4 and LONG_CNT=16.
// Edge numbering: edge 1 is the first rising edge after the input change.
// Output bundle {btn_level, press_pulse, release_pulse, long_pulse}.
module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic       button;
  logic [2:0] sw_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [2:0] sw_out;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .DEBOUNCE_CNT(4),
    .CNT_WIDTH   (3),
    .LONG_CNT    (16),
    .LONG_WIDTH  (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .sw_in        (sw_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .sw_out       (sw_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    button = 1'b0;
    sw_in  = 3'b000;
    step();
    step();
    chk("reset_outs", {4'b0, btn_level, press_pulse, release_pulse, long_pulse}, 8'h00);
    chk("reset_sw", {5'b0, sw_out}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_outs", {4'b0, btn_level, press_pulse, release_pulse, long_pulse}, 8'h00);
    end

    // Clean press: press_pulse and btn_level on edge 7
    button = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("press_e%0d", e), {4'b0, btn_level, press_pulse, release_pulse, long_pulse},
          (e == 7) ? 8'b0000_1100 : 8'b0000_0000);
    end

    // Long hold: single long_pulse 16 cycles after press_pulse (edge 23)
    for (int e = 8; e <= 37; e++) begin
      step();
      chk($sformatf("hold_e%0d", e), {4'b0, btn_level, press_pulse, release_pulse, long_pulse},
          (e == 23) ? 8'b0000_1001 : 8'b0000_1000);
    end

    // Release glitch: button low for 2 cycles only
    button = 1'b0;
    step();
    step();
    button = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("glitch_%0d", i), {4'b0, btn_level, press_pulse, release_pulse, long_pulse},
          8'b0000_1000);
    end

    // Clean release: release_pulse on edge 7, btn_level drops with it
    button = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("release_e%0d", e), {4'b0, btn_level, press_pulse, release_pulse, long_pulse},
          (e == 7) ? 8'b0000_0010 : ((e == 8) ? 8'b0000_0000 : 8'b0000_1000));
    end

    // Bounce 1,0,1,0 then 0: nothing qualifies
    button = 1'b1; step();
    chk("bounce_a", {4'b0, btn_level, press_pulse, release_pulse, long_pulse}, 8'h00);
    button = 1'b0; step();
    chk("bounce_b", {4'b0, btn_level, press_pulse, release_pulse, long_pulse}, 8'h00);
    button = 1'b1; step();
    chk("bounce_c", {4'b0, btn_level, press_pulse, release_pulse, long_pulse}, 8'h00);
    button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("bounce_tail%0d", i), {4'b0, btn_level, press_pulse, release_pulse, long_pulse},
          8'h00);
    end

    // Switches 000 -> 101: sw_out updates on edge 7
    sw_in = 3'b101;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("sw_e%0d", e), {5'b0, sw_out}, (e >= 7) ? 8'h05 : 8'h00);
    end

    // Switch glitch 101 -> 111 (2 cycles) -> 101: sw_out holds 101
    sw_in = 3'b111;
    step();
    step();
    sw_in = 3'b101;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("sw_glitch%0d", i), {5'b0, sw_out}, 8'h05);
    end

    // Reset during PRESS_WAIT
    button = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_pw_outs", {1'b0, btn_level, press_pulse, release_pulse, long_pulse, sw_out}, 8'h00);
    button = 1'b0;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("post_rst_pw_e%0d", e),
          {1'b0, btn_level, press_pulse, release_pulse, long_pulse, sw_out},
          (e >= 7) ? 8'h05 : 8'h00);
    end

    // Reset during HELD
    button = 1'b1;
    for (int e = 1; e <= 8; e++) step();
    chk("held_before_rst", {4'b0, btn_level, press_pulse, release_pulse, long_pulse}, 8'b0000_1000);
    #2 rst = 1'b1;
    #1;
    chk("rst_held_outs", {1'b0, btn_level, press_pulse, release_pulse, long_pulse, sw_out}, 8'h00);
    button = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("post_rst_held_e%0d", e),
          {1'b0, btn_level, press_pulse, release_pulse, long_pulse, sw_out},
          (e >= 7) ? 8'h05 : 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 2000000: number of consecutive stable synchronised cycles that qualifies a change; legal range 2 to 2^CNT_WIDTH-1.
REQ-002 Parameter CNT_WIDTH, default 21: width of the debounce counters.
REQ-003 Parameter LONG_CNT, default 100000000: number of cycles in the debounced-held state before long_pulse fires; legal range 1 to 2^LONG_WIDTH-1.
REQ-004 Parameter LONG_WIDTH, default 27: width of the hold counter.
REQ-005 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port button, input, 1: raw asynchronous push-button; 1 means pressed.
REQ-008 Port sw_in, input, 3: raw asynchronous slide switches; [1:0] carry the frequency select and [2] carries the direction select.
REQ-009 Port btn_level, output, 1: debounced button level.
REQ-010 Port press_pulse, output, 1: one-cycle strobe on each debounced press.
REQ-011 Port release_pulse, output, 1: one-cycle strobe on each debounced release.
REQ-012 Port long_pulse, output, 1: one-cycle strobe when a press has been held for LONG_CNT cycles.
REQ-013 Port sw_out, output, 3: debounced switch vector with the same bit mapping as sw_in.

Function
REQ-014 button and sw_in SHALL each pass through a two-flop synchroniser (s1, s2); only the s2 values feed any further logic.
REQ-015 The button FSM SHALL have the states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-016 In IDLE, when s2=1 the FSM SHALL go to PRESS_WAIT and clear the debounce counter to 0.
REQ-017 In PRESS_WAIT, when s2=0 the FSM SHALL return to IDLE with no pulse; otherwise the counter increments each cycle.
REQ-018 In PRESS_WAIT, when counter=DEBOUNCE_CNT-1 and s2=1 the FSM SHALL go to HELD, clearing the hold counter.
REQ-019 With a clean press, the state SHALL become HELD on edge DEBOUNCE_CNT+3, counting as edge 1 the first edge that samples button high.
REQ-020 press_pulse SHALL be 1 only during the first cycle in HELD that is entered from PRESS_WAIT.
REQ-021 btn_level SHALL be 1 in the HELD and RELEASE_WAIT states, and 0 otherwise.
REQ-022 In HELD, the hold counter SHALL increment each cycle and saturate at LONG_CNT-1.
REQ-023 long_pulse SHALL be 1 for exactly one cycle, on the cycle the hold counter first reaches LONG_CNT-1; it fires at most once per press.
REQ-024 In HELD, when s2=0 the FSM SHALL go to RELEASE_WAIT and clear the debounce counter.
REQ-025 In RELEASE_WAIT, when s2=1 the FSM SHALL return to HELD with no pulse; the hold counter is retained, not restarted.
REQ-026 In RELEASE_WAIT, when counter=DEBOUNCE_CNT-1 and s2=0 the FSM SHALL go to IDLE, with release_pulse=1 for exactly the first IDLE cycle.
REQ-027 The switch filter SHALL use one shared counter, cleared whenever the synchronised sw vector differs from its value in the previous cycle.
REQ-028 The switch counter SHALL increment while the vector is stable and saturate at DEBOUNCE_CNT-1.
REQ-029 When the synchronised vector differs from sw_out and the counter equals DEBOUNCE_CNT-1, sw_out SHALL take the vector on the next edge.
REQ-030 A switch change that reverts before qualifying SHALL NOT alter sw_out.
REQ-031 press_pulse, release_pulse and long_pulse SHALL be mutually exclusive in any single cycle.
REQ-032 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-033 rst=1 SHALL immediately force the following, regardless of clk: FSM=IDLE, all synchroniser flops=0, all counters=0, btn_level=0, all pulses=0, sw_out=3'b000.
REQ-034 A reset asserted mid-press or mid-filter SHALL discard all progress, and no pulse SHALL be emitted on reset release.
REQ-035 After reset release, a switch vector already held non-zero SHALL appear on sw_out through the normal qualification path of REQ-027 to REQ-029.

Verification (DEBOUNCE_CNT=4, LONG_CNT=16)
REQ-036 Clean press: button 0->1 and held -> press_pulse=1 and btn_level=1 exactly on edge 7 (edge 1 is the first sampling edge), with release_pulse=0 and long_pulse=0.
REQ-037 Bounce: button pattern 1,0,1,0 with one cycle each, then 0 -> no pulses and btn_level stays 0.
REQ-038 Long hold: press held for 30 cycles after HELD -> exactly one long_pulse, 16 cycles after press_pulse.
REQ-039 Release glitch: in HELD, button 0 for 2 cycles, then 1 -> no release_pulse, btn_level stays 1; a later clean release gives release_pulse on edge 7 of the release.
REQ-040 Switches: sw_in 000->101 stable -> sw_out=101 on edge 7 (edge 1 is the sampling edge); sw_in 101->111->101 with the 111 lasting 2 cycles -> sw_out stays 101.
REQ-041 Reset mid-operation: rst asserted during PRESS_WAIT and during HELD -> outputs reach their reset values asynchronously, and no pulses occur after release while button=0.
